// File: rtl/pixel_framebuffer_if.sv
// Host write stream and LED-driver read port of the double-buffered frame store.
interface pixel_framebuffer_if #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int BPC    = 4
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic              wr_valid;
    logic              wr_ready;
    logic [3*BPC-1:0]  wr_data;
    logic              wr_sof;
    logic [XW-1:0]     rd_x;
    logic [YW-1:0]     rd_y;
    logic [7:0]        rd_subframe;
    logic              rd_frame_start;
    logic [2:0]        rd_rgb;
    logic              sync_err;

    modport master (
        output wr_valid, wr_data, wr_sof, rd_x, rd_y, rd_subframe, rd_frame_start,
        input  wr_ready, rd_rgb, sync_err
    );

    modport slave (
        input  wr_valid, wr_data, wr_sof, rd_x, rd_y, rd_subframe, rd_frame_start,
        output wr_ready, rd_rgb, sync_err
    );
endinterface

// File: rtl/pixel_framebuffer.sv
// Double-buffered WIDTHxHEIGHT RGB frame store: host fills the back bank, the
// driver reads 1-bit PWM planes from the front bank, banks swap on frame boundaries.
module pixel_framebuffer #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int BPC    = 4
) (
    input  logic                clk,
    input  logic                reset,
    pixel_framebuffer_if.slave  bus
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = $clog2(NPIX);
    localparam int PW   = 3 * BPC;

    typedef enum logic { FILL, PENDING } wr_state_e;

    wr_state_e         state_q, state_d;
    logic              front_q, front_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic              shown_q, shown_d;
    logic              sync_err_q, sync_err_d;
    logic              wr_ready_q, wr_ready_d;

    logic              we;
    logic [AW-1:0]     wa;

    logic [PW-1:0]     mem [2*NPIX];
    logic [AW:0]       rd_addr_d;
    logic [PW-1:0]     rd_word_q;
    logic [BPC-1:0]    phase_q, phase_d;
    logic              rd_shown_q, rd_shown_d;

    logic [BPC-1:0]    ch_r, ch_g, ch_b;
    logic              unused_subframe_hi;

    assign unused_subframe_hi = ^bus.rd_subframe[7:BPC];

    always_comb begin
        state_d    = state_q;
        front_d    = front_q;
        wr_addr_d  = wr_addr_q;
        shown_d    = shown_q;
        sync_err_d = sync_err_q;
        we         = 1'b0;
        wa         = wr_addr_q;

        case (state_q)
            FILL: begin
                if (bus.wr_valid && wr_ready_q) begin
                    we = 1'b1;
                    // A start-of-frame word always restarts at pixel 0
                    wa = bus.wr_sof ? '0 : wr_addr_q;
                    if (bus.wr_sof && (wr_addr_q != '0))
                        sync_err_d = 1'b1;
                    wr_addr_d = wa + 1'b1;
                    if (wa == AW'(NPIX - 1))
                        state_d = PENDING;
                end
            end
            PENDING: begin
                if (bus.rd_frame_start) begin
                    front_d   = ~front_q;
                    wr_addr_d = '0;
                    shown_d   = 1'b1;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        wr_ready_d = (state_d == FILL);

        // Bank select and shown gate are captured with the address so a swap
        // only affects reads presented after it.
        rd_addr_d  = {front_q, bus.rd_y, bus.rd_x};
        phase_d    = bus.rd_subframe[BPC-1:0];
        rd_shown_d = shown_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            front_q    <= 1'b0;
            wr_addr_q  <= '0;
            shown_q    <= 1'b0;
            sync_err_q <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_shown_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            front_q    <= front_d;
            wr_addr_q  <= wr_addr_d;
            shown_q    <= shown_d;
            sync_err_q <= sync_err_d;
            wr_ready_q <= wr_ready_d;
            rd_shown_q <= rd_shown_d;
        end
    end

    // Frame RAM: one write port into the back bank, one synchronous read port.
    always_ff @(posedge clk) begin
        if (we && !reset)
            mem[{~front_q, wa}] <= bus.wr_data;
        rd_word_q <= mem[rd_addr_d];
        phase_q   <= phase_d;
    end

    assign ch_r = rd_word_q[PW-1 -: BPC];
    assign ch_g = rd_word_q[2*BPC-1 -: BPC];
    assign ch_b = rd_word_q[BPC-1:0];

    assign bus.rd_rgb   = {rd_shown_q & (ch_r > phase_q),
                           rd_shown_q & (ch_g > phase_q),
                           rd_shown_q & (ch_b > phase_q)};
    assign bus.wr_ready = wr_ready_q;
    assign bus.sync_err = sync_err_q;
endmodule

// File: doc/pixel_framebuffer.md
# pixel_framebuffer

Double-buffered 64x64 RGB444 frame store that sits directly upstream of the LED matrix row driver, in place of a procedural painter. A host-side stream writes whole frames into the back buffer. The driver reads pixels by (x, y, subframe) and gets 1-bit-per-channel PWM data for the current bit-plane. Buffers swap only at a driver frame boundary, so the panel never shows a torn frame.

## Interface
- WIDTH, 64, columns per row (power of two)
- HEIGHT, 64, rows (power of two; top and bottom halves both read from this store)
- BPC, 4, bits per colour channel; pixel word is {R,G,B}, 3*BPC bits
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  pixel word offered
- wr_ready  out  1  block accepts the word when wr_valid & wr_ready
- wr_data  in  3*BPC  pixel {R[BPC-1:0], G, B}
- wr_sof  in  1  qualifies the accepted word as pixel 0 of a new frame
- rd_x  in  log2(WIDTH)  read column
- rd_y  in  log2(HEIGHT)  read row
- rd_subframe  in  8  PWM phase; only bits [BPC-1:0] are used
- rd_frame_start  in  1  one-cycle pulse from the driver at a frame boundary
- rd_rgb  out  3  {R,G,B} on/off for the pixel and phase presented one cycle earlier
- sync_err  out  1  sticky: wr_sof seen at a non-zero write address

## Operation
- Storage: 2 x WIDTH*HEIGHT words. Bank select bit `front` picks the displayed bank; the back bank is `~front`.
- Write FSM, two states:
  - FILL: wr_ready=1. Each accepted word goes to {~front, wr_addr}, and wr_addr increments.
    - Accepted with wr_sof=1: the word goes to address 0 and wr_addr becomes 1. If wr_addr was not 0, sync_err is set; the partial frame is discarded and the restart is not otherwise penalised.
    - Accepted word at address WIDTH*HEIGHT-1: next state is PENDING.
  - PENDING: wr_ready=0; a complete frame waits in the back bank. When rd_frame_start=1, `front` toggles, wr_addr resets to 0, `shown` sets to 1, and the next state is FILL.
- wr_addr width is log2(WIDTH*HEIGHT). It never wraps in FILL, because reaching the last address forces PENDING.
- Read path:
  - The address {front, rd_y, rd_x} is registered into the RAM (block/SPRAM style). rd_subframe[BPC-1:0] is registered alongside it as `phase`.
  - rd_rgb[c] = shown & (channel_c > phase). Channel value 0 is always off; 2^BPC-1 is on for 2^BPC-1 of 2^BPC phases.
- `front` is sampled with the read address. A swap therefore affects reads presented from the cycle after the swap.
- Reset (reset=1 at a clock edge):
  - front=0, state=FILL, wr_addr=0, shown=0, sync_err=0, rd_rgb=0, wr_ready=0.
  - wr_ready rises on the first cycle after reset deasserts.
  - RAM contents are not cleared. The `shown` gate guarantees a dark panel until the first completed frame is swapped in.
  - Reset mid-frame abandons the partial frame; the next frame restarts at address 0.

## Timing
- Read latency is exactly 1 cycle: coordinates and phase presented at edge N produce rd_rgb valid after edge N+1. The driver presents coordinates one cycle ahead of its shift clock. The read path has no stalls and accepts a new address every cycle.
- Write throughput is 1 word per cycle in FILL.
- wr_ready is registered. It drops in the cycle after the last pixel is accepted, so no word is accepted while in PENDING.
- Simultaneous events:
  - Last pixel accepted in the same cycle as rd_frame_start: no swap. The block enters PENDING and swaps at the next rd_frame_start.
  - rd_frame_start while in FILL: ignored.
  - wr_sof with wr_valid but wr_ready=0: no effect; the host must hold the word.
- Swap to first new-bank read data: rd_frame_start at edge N sets front at N+1. A read presented at N+1 returns new-bank data after N+2.

## Test plan
- Reset, then read any address with phase 0 -> rd_rgb=0 for every pixel until the first swap; wr_ready=0 during reset and 1 one cycle after.
- Stream 4096 words with R=pixel index mod 16 (G=B=0, wr_sof on the first), then pulse rd_frame_start -> wr_ready=0 after the last word and 1 after the pulse. Reading x=5, y=0 at phases 4 then 5 gives rd_rgb=3'b100 then 3'b000.
- Channel value 15 vs phases 0..15 -> on for 15 phases, off only at phase 15. Value 0 -> never on.
- Stream 100 words, then wr_sof -> sync_err=1 and stays set. The next frame of 4096 words completes and swaps normally.
- Last word accepted in the same cycle as rd_frame_start -> front unchanged and state PENDING. The next pulse swaps; reads before it return old-bank data.
- Assert reset at word 2000 of a frame -> rd_rgb=0 and sync_err=0. A fresh 4096-word frame followed by a pulse displays correctly.
